// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline encodings for the hazard controller: mult/div op codes,
// forwarding selects, Tuse sentinel and the EX/MEM scoreboard entry.
package hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } sb_entry_t;

    // Tnew as the instruction advances one stage; floors at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_hazard(input logic [4:0] s, input logic [1:0] tuse,
                                        input sb_entry_t e);
        return (s != 5'd0) && (tuse != TUSE_NONE) && (e.dst == s) && (e.tnew > tuse);
    endfunction

    // EX wins over MEM: it holds the younger write to the same register.
    function automatic logic [1:0] fwd_pick(input logic [4:0] s, input sb_entry_t e,
                                            input sb_entry_t m);
        if (s == 5'd0)
            return FWD_RF;
        else if (e.dst == s && e.tnew == 2'd0)
            return FWD_E;
        else if (m.dst == s && m.tnew == 2'd0)
            return FWD_M;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request fields and pipeline control responses of the hazard controller.
interface hazard_ctrl_if;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic [2:0] d_md_op;
    logic       d_md_use;
    logic       pc_en;
    logic       fd_en;
    logic       de_en;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       md_start;
    logic       md_busy;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_md_op, d_md_use,
        input  pc_en, fd_en, de_en, fwd_rs_sel, fwd_rt_sel, md_start, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, d_md_op, d_md_use,
        output pc_en, fd_en, de_en, fwd_rs_sel, fwd_rt_sel, md_start, md_busy
    );
endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// Mult/div issue sequencer: registered start pulse, latched op and busy countdown.
module md_sequencer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] d_md_op,
    input  logic       stall,
    output logic       md_start,
    output logic       md_busy
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] md_cnt;
    logic [2:0]       op_q;
    logic             issue;
    logic             op_is_div;

    assign issue     = (d_md_op != MD_NONE) && !stall;
    assign op_is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
    // Combinational from state so an async reset drops busy at once.
    assign md_busy   = (md_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_start <= 1'b0;
            op_q     <= MD_NONE;
            md_cnt   <= '0;
        end else begin
            md_start <= issue;
            if (issue)
                op_q <= d_md_op;
            // The start cycle itself is not busy; the count begins after it.
            if (md_start && md_cnt == '0)
                md_cnt <= op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage hazard controller: EX/MEM Tnew scoreboard, stall/bubble enables,
// ID-stage forwarding selects and the mult/div sequencer.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);
    sb_entry_t e_q;
    sb_entry_t m_q;
    logic      data_stall;
    logic      md_stall;
    logic      stall;
    logic      md_req;
    logic      md_start;
    logic      md_busy;

    assign data_stall = src_hazard(bus.d_rs, bus.d_tuse_rs, e_q) |
                        src_hazard(bus.d_rs, bus.d_tuse_rs, m_q) |
                        src_hazard(bus.d_rt, bus.d_tuse_rt, e_q) |
                        src_hazard(bus.d_rt, bus.d_tuse_rt, m_q);

    // Any HI/LO consumer or new op waits until the unit is idle and not starting.
    assign md_req   = (bus.d_md_op != MD_NONE) || bus.d_md_use;
    assign md_stall = md_req && (md_start || md_busy);
    assign stall    = data_stall || md_stall;

    assign bus.pc_en      = ~stall;
    assign bus.fd_en      = ~stall;
    assign bus.de_en      = ~stall;
    assign bus.fwd_rs_sel = fwd_pick(bus.d_rs, e_q, m_q);
    assign bus.fwd_rt_sel = fwd_pick(bus.d_rt, e_q, m_q);
    assign bus.md_start   = md_start;
    assign bus.md_busy    = md_busy;

    // A stalled cycle pushes a bubble into EX while MEM keeps draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            m_q.dst  <= e_q.dst;
            m_q.tnew <= tnew_dec(e_q.tnew);
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q.dst  <= bus.d_dst;
                e_q.tnew <= bus.d_tnew;
            end
        end
    end

    md_sequencer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_seq (
        .clk     (clk),
        .reset   (reset),
        .d_md_op (bus.d_md_op),
        .stall   (stall),
        .md_start(md_start),
        .md_busy (md_busy)
    );
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and multiply/divide scheduler for the five-stage pipeline.
- Keeps a shadow scoreboard of the destination register and Tnew for the instructions in EX and MEM.
- Compares that scoreboard against the Tuse of the instruction in ID, and produces stall and bubble controls for the PC, IF/ID and ID/EX registers.
- Selects ID-stage forwarding sources.
- Sequences the multi-cycle mult/div unit with a busy counter.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 clears all state)
- d_rs, d_rt  input  5  source registers of the ID instruction
- d_tuse_rs, d_tuse_rt  input  2  Tuse per source; 3 = source unused
- d_dst  input  5  destination register of the ID instruction; 0 = none
- d_tnew  input  2  Tnew of the ID instruction on entering EX
- d_md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu
- d_md_use  input  1  ID instruction is mfhi/mflo/mthi/mtlo
- pc_en  output  1  PC write enable
- fd_en  output  1  IF/ID enable
- de_en  output  1  ID/EX enable; 0 loads a bubble
- fwd_rs_sel, fwd_rt_sel  output  2  ID operand source: 0 regfile, 1 EX result, 2 MEM result
- md_start  output  1  one-cycle start pulse to the mult/div unit (instruction in EX)
- md_busy  output  1  mult/div unit is computing

## Operation
**Scoreboard entries** E{dst,tnew} and M{dst,tnew} are registered.
- Not stalled: E <= {d_dst,d_tnew}; M <= {E.dst, sat(E.tnew-1)}.
- Stalled: E <= {0,0}; M advances as above.
- sat(x) floors at 0.

**Data stall** per source s in {rs,rt}, evaluated only when s != 0:
- Stall if (E.dst==s and E.tnew > tuse_s), or if (M.dst==s and M.tnew > tuse_s).
- tuse_s = 3 never stalls.

**Mult/div stall**
- Stall if (d_md_op != 0 or d_md_use) and (md_start or md_busy).

**Stall handling**
- stall = data stall OR mult/div stall.
- While stalled: pc_en = fd_en = de_en = 0.
- Otherwise all three are 1.

**Forwarding** per source s != 0:
- fwd = 1 if E.dst==s and E.tnew==0.
- Else fwd = 2 if M.dst==s and M.tnew==0.
- Else fwd = 0.
- EX has priority over MEM. Register 0 always selects 0.
- WB needs no forwarding: the regfile writes through.

**Start generation**
- md_start is registered: set for one cycle when d_md_op != 0 and the cycle is not stalled.
- A mult/div op held by any stall does not start.

**Counter**
- md_cnt loads MULT_CYCLES (op 1-2) or DIV_CYCLES (op 3-4) in the md_start cycle.
- After that it decrements to 0.
- md_busy = (md_cnt != 0).
- The op code is latched alongside md_start.

## Timing
- Reset values: E, M, md_cnt and md_start are cleared. Outputs: pc_en=1, fd_en=1, de_en=1, fwd_*=0, md_start=0, md_busy=0.
- Reset asserted mid-operation aborts the count immediately. md_busy drops asynchronously.
- Stall and forwarding outputs are combinational from inputs and state, valid within the same cycle.
- The scoreboard and counter update on the rising edge of clk.
- mult followed directly by mflo:
  - mflo stalls for 1 cycle (md_start) plus MULT_CYCLES, i.e. 6 cycles.
  - It issues on the cycle after md_busy falls.
- Back-to-back mult/div: the second op stalls the same way. The counter is never reloaded while busy.
- Data and mult/div stalls occurring together produce a single stall, not additive ones.
- md_cnt width is clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Structure
- Shared pipeline package:
  - md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - FWD_RF, FWD_E, FWD_M.
  - TUSE_NONE = 3.
  - The scoreboard entry typedef {dst[4:0], tnew[1:0]}.
- One sub-module, md_sequencer, holds md_start, md_cnt and md_busy.
- The top level holds the scoreboard, stall logic and forwarding logic.

## Test plan
- lw $1 (d_tnew=2), then beq $1 (tuse_rs=0) → 2 stall cycles (pc_en=0, de_en=0), then fwd_rs_sel=0 and issue.
- lw $1, then add $2,$1,$3 (tuse_rs=1) → exactly 1 stall cycle.
- jal (d_dst=31, d_tnew=0), then jr $31 (tuse=0) → no stall, fwd_rs_sel=1 for one cycle.
- mult, then mflo → md_start pulses once; md_busy high for 5 cycles; mflo stalled for 6 cycles; with DIV_CYCLES=10, div gives an 11-cycle stall.
- Writes to $0 with a dependent reader of $0 → no stall, fwd=0. Data hazard on a mult in ID → md_start is withheld until the stall clears.
- reset pulled low for 1 cycle at md_cnt=3 → md_busy=0 immediately, scoreboard cleared, all enables 1.
